// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encodings, frame constants, baud divisor.
// Optional even-parity framing is selected with UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled and pulses tick on the wrap cycle.
// Held at zero while disabled so each frame starts on a full bit period.
module uart_baud_tick #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// Byte-to-UART transmitter: accepts a byte on require and sends it 8N1 on txd, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       require,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);

    generate
        if (BAUD_DIV < 2) begin : g_bad_div
            $error("uart_tx_byte: BAUD_DIV = CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        tick;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    uart_baud_tick #(
        .DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    // Gated by rst_n so no byte is consumed while the block is held in reset.
    assign require = rst_n && (state_q == IDLE) && valid;

    // txd is registered from the next state so the start bit appears right after acceptance.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (valid) begin
                    state_d   = START;
                    shift_d   = data;
                    bit_idx_d = '0;
                    txd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_d     = ^data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        txd_d   = par_q;
`else
                        state_d = STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Self-checking bench for uart_tx_byte at BAUD_DIV=4 (CLK_FREQ=1000, BAUD_RATE=250).
// Honours UART_TX_PARITY_EN to expect 8E1 framing.
module tb_uart_tx_byte;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FB = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       require;
    logic       txd;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_byte #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (250)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data),
        .valid   (valid),
        .require (require),
        .txd     (txd),
        .busy    (busy)
    );

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;  // 8N1 line bits, index = bit time
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame built straight from the line format: start, 8 data LSB first, [parity], stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((int'(d) / (1 << i)) % 2) == 1;
            ones  += ((int'(d) / (1 << i)) % 2);
        end
        if (PAR_EN) begin
            f[9]  = (ones % 2) == 1;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [10:0] table_frame(input vec_t v);
        if (PAR_EN) return {1'b1, v.par, v.frame[8:0]};
        return {1'b1, v.frame};
    endfunction

    // Offer a byte from mid-cycle; returns just after the acceptance edge.
    task automatic accept(input logic [7:0] d, input bit hold, input string tag);
        data  = d;
        valid = 1'b1;
        #1;
        chk({tag, "_require_hi"}, require, 1'b1);
        @(posedge clk);
        #1;
        chk({tag, "_require_pulse"}, require, 1'b0);
        if (!hold) valid = 1'b0;
    endtask

    // Starts just after the acceptance edge; samples each bit mid-period, ends after the frame.
    task automatic check_frame(input logic [10:0] exp, input string tag);
        for (int i = 0; i < FB; i++) begin
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("%s_bit%0d", tag, i), txd, exp[i]);
            chk($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            chk($sformatf("%s_noreq%0d", tag, i), require, 1'b0);
            @(posedge clk);
            #1;
            if (i == FB - 1) chk({tag, "_busy_last"}, busy, 1'b1);
            @(posedge clk);
            #1;
        end
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_txd_end"}, txd, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'h41, 10'b1010000010, 1'b0};
        vecs[1] = '{8'h43, 10'b1010000110, 1'b1};
        vecs[2] = '{8'h30, 10'b1001100000, 1'b0};
        vecs[3] = '{8'h0A, 10'b1000010100, 1'b0};
        vecs[4] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[5] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[6] = '{8'h55, 10'b1010101010, 1'b0};
        vecs[7] = '{8'h80, 10'b1100000000, 1'b1};

        // Held in reset with a byte on offer: no request, line idle.
        rst_n = 1'b0;
        valid = 1'b1;
        data  = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_require", require, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        accept(8'h41, 1'b0, "first");
        check_frame(table_frame(vecs[0]), "first41");

        // Nothing offered: line stays high, no request.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("idle_txd", txd, 1'b1);
            chk("idle_require", require, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        foreach (vecs[k]) begin
            accept(vecs[k].d, 1'b0, $sformatf("vec%0d", k));
            check_frame(table_frame(vecs[k]), $sformatf("vec%0d", k));
            @(posedge clk);
            #1;
        end

        // Back-to-back with valid held; data changed mid-frame must not disturb the frame.
        accept(8'h30, 1'b1, "b2b0");
        data = 8'h0A;
        check_frame(table_frame(vecs[2]), "b2b0");
        chk("b2b_second_req_at_41", require, 1'b1);
        accept(8'h0A, 1'b0, "b2b1");
        check_frame(table_frame(vecs[3]), "b2b1");

        // Reset during data bit index 3 (line bit 4, cycles 16..19) of an all-zero byte.
        @(posedge clk);
        #1;
        accept(8'h00, 1'b0, "midrst");
        repeat (17) @(posedge clk);
        #1;
        chk("midrst_pre_txd", txd, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_txd_async", txd, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_rereq", require, 1'b0);
            chk("midrst_idle_txd", txd, 1'b1);
        end
        accept(8'hA5, 1'b0, "postrst");
        check_frame(model_frame(8'hA5), "postrst");

        // Randomised bytes and idle gaps against the line-format model.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            int gap;
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                chk("rnd_gap_txd", txd, 1'b1);
                chk("rnd_gap_req", require, 1'b0);
            end
            accept(d, 1'b0, "rnd");
            data = 8'($urandom);
            check_frame(model_frame(d), $sformatf("rnd%0d_%02h", n, d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
